// File: rtl/control_pipeline.sv
// control_pipeline: carries the decode-stage control word through the E, M
// and W stages. Each stage has a valid bit. E can be stalled or flushed,
// while M and W always advance.
// Write enables are qualified by the stage valid bit, so a bubble never
// writes, whatever its stale field values are.
// Optional feature: define CTRL_PIPE_PERF_EN to add a saturating
// bubble_count output that counts the cycles in which W holds no instruction.
module control_pipeline #(
  parameter int ALU_OP_W = 3,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_D,
  input  logic                ctrl_register_file_WE_D,
  input  logic                ctrl_srcB_D,
  input  logic                ctrl_register_file_WA_D,
  input  logic                ctrl_data_memory_WE_D,
  input  logic                ctrl_result_D,
  input  logic [ALU_OP_W-1:0] ctrl_ALU_op_D,
  input  logic                stall_E,
  input  logic                flush_E,
  output logic                valid_E,
  output logic                valid_M,
  output logic                valid_W,
  output logic                ctrl_srcB_E,
  output logic [ALU_OP_W-1:0] ctrl_ALU_op_E,
  output logic                ctrl_result_E,
  output logic                ctrl_register_file_WE_E,
  output logic                ctrl_data_memory_WE_M,
  output logic                ctrl_register_file_WE_M,
  output logic                ctrl_result_M,
  output logic                ctrl_register_file_WE_W,
  output logic                ctrl_register_file_WA_W,
  output logic                ctrl_result_W
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0]   bubble_count
`endif
);

  // E-stage registers hold the raw control word. The write-enable fields
  // are qualified by valid at the output.
  logic                valid_e_r;
  logic                rf_we_e_r;
  logic                srcb_e_r;
  logic                wa_e_r;
  logic                dm_we_e_r;
  logic                result_e_r;
  logic [ALU_OP_W-1:0] alu_op_e_r;

  logic                valid_m_r;
  logic                rf_we_m_r;
  logic                wa_m_r;
  logic                dm_we_m_r;
  logic                result_m_r;

  logic                valid_w_r;
  logic                rf_we_w_r;
  logic                wa_w_r;
  logic                result_w_r;

  // E stage: reset, then flush (bubble), then stall (hold), then capture D
  always_ff @(posedge clk) begin
    if (rst || flush_E) begin
      valid_e_r  <= 1'b0;
      rf_we_e_r  <= 1'b0;
      srcb_e_r   <= 1'b0;
      wa_e_r     <= 1'b0;
      dm_we_e_r  <= 1'b0;
      result_e_r <= 1'b0;
      alu_op_e_r <= '0;
    end else if (stall_E) begin
      valid_e_r  <= valid_e_r;
      rf_we_e_r  <= rf_we_e_r;
      srcb_e_r   <= srcb_e_r;
      wa_e_r     <= wa_e_r;
      dm_we_e_r  <= dm_we_e_r;
      result_e_r <= result_e_r;
      alu_op_e_r <= alu_op_e_r;
    end else begin
      valid_e_r  <= valid_D;
      rf_we_e_r  <= ctrl_register_file_WE_D;
      srcb_e_r   <= ctrl_srcB_D;
      wa_e_r     <= ctrl_register_file_WA_D;
      dm_we_e_r  <= ctrl_data_memory_WE_D;
      result_e_r <= ctrl_result_D;
      alu_op_e_r <= ctrl_ALU_op_D;
    end
  end

  // M stage: takes old E, except that a stall without a flush inserts a bubble
  always_ff @(posedge clk) begin
    if (rst || (stall_E && !flush_E)) begin
      valid_m_r  <= 1'b0;
      rf_we_m_r  <= 1'b0;
      wa_m_r     <= 1'b0;
      dm_we_m_r  <= 1'b0;
      result_m_r <= 1'b0;
    end else begin
      valid_m_r  <= valid_e_r;
      rf_we_m_r  <= rf_we_e_r;
      wa_m_r     <= wa_e_r;
      dm_we_m_r  <= dm_we_e_r;
      result_m_r <= result_e_r;
    end
  end

  // W stage: always advances from M
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w_r  <= 1'b0;
      rf_we_w_r  <= 1'b0;
      wa_w_r     <= 1'b0;
      result_w_r <= 1'b0;
    end else begin
      valid_w_r  <= valid_m_r;
      rf_we_w_r  <= rf_we_m_r;
      wa_w_r     <= wa_m_r;
      result_w_r <= result_m_r;
    end
  end

  assign valid_E                 = valid_e_r;
  assign valid_M                 = valid_m_r;
  assign valid_W                 = valid_w_r;
  assign ctrl_srcB_E             = srcb_e_r;
  assign ctrl_ALU_op_E           = alu_op_e_r;
  // Left ungated: the hazard unit qualifies it with valid_E for load-use detection.
  assign ctrl_result_E           = result_e_r;
  assign ctrl_register_file_WE_E = valid_e_r & rf_we_e_r;
  assign ctrl_data_memory_WE_M   = valid_m_r & dm_we_m_r;
  assign ctrl_register_file_WE_M = valid_m_r & rf_we_m_r;
  assign ctrl_result_M           = result_m_r;
  assign ctrl_register_file_WE_W = valid_w_r & rf_we_w_r;
  assign ctrl_register_file_WA_W = wa_w_r;
  assign ctrl_result_W           = result_w_r;

`ifdef CTRL_PIPE_PERF_EN
  logic [PERF_W-1:0] bubble_count_r;

  // Count the edges at which W holds a bubble. The count saturates at its maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_r <= '0;
    end else if (!valid_w_r && (bubble_count_r != {PERF_W{1'b1}})) begin
      bubble_count_r <= bubble_count_r + PERF_W'(1);
    end else begin
      bubble_count_r <= bubble_count_r;
    end
  end

  assign bubble_count = bubble_count_r;
`endif

endmodule
